fifo_sync_ex: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's simple synchronous FIFO, for buffering between streaming blocks in one clock domain.
- Same push/pop interface as before, plus configurable almost-full/almost-empty thresholds, overflow/underflow error pulses, a synchronous flush and a high-water mark.
- Read timing is selectable at compile time: registered read or first-word-fall-through (FWFT).

---
 rtl/fifo_sync_ex.sv | 131 +++++++++++++
 tb/tb_fifo_sync_ex.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_ex.sv
// fifo_sync_ex: single-clock FIFO with almost-full/empty thresholds, error pulses, flush and high-water mark.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through read; default build uses a registered read port.
module fifo_sync_ex #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_ena,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  wr_overflow,
    input  logic                  rd_ena,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic                  rd_underflow,
    output logic [ADDR_WIDTH:0]   dat_cnt,
    output logic [ADDR_WIDTH:0]   hwm
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
            $error("fifo_sync_ex: AF_LEVEL or AE_LEVEL out of legal range");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic                  push_acc_s;
    logic                  pop_acc_s;
    logic [CNT_W-1:0]      cnt_next_s;

    // Acceptance depends only on registered flags, so a pop never frees room for a same-cycle push.
    assign push_acc_s = wr_ena && !wr_full && !clr;
    assign pop_acc_s  = rd_ena && !rd_empty && !clr;

    // Next stored-word count; flush wins over any transfer.
    always_comb begin
        cnt_next_s = dat_cnt;
        if (clr) begin
            cnt_next_s = '0;
        end else if (push_acc_s && !pop_acc_s) begin
            cnt_next_s = dat_cnt + CNT_W'(1);
        end else if (!push_acc_s && pop_acc_s) begin
            cnt_next_s = dat_cnt - CNT_W'(1);
        end else begin
            cnt_next_s = dat_cnt;
        end
    end

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_r] <= wr_dat;
        end
    end

    // Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_WIDTH'(1);
            end
            if (pop_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_WIDTH'(1);
            end
        end
    end

    // Count, level flags and high-water mark all register off the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_cnt      <= '0;
            hwm          <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            dat_cnt      <= cnt_next_s;
            wr_full      <= (cnt_next_s == CNT_W'(DEPTH));
            almost_full  <= (cnt_next_s >= CNT_W'(AF_LEVEL));
            rd_empty     <= (cnt_next_s == CNT_W'(0));
            almost_empty <= (cnt_next_s <= CNT_W'(AE_LEVEL));
            if (clr) begin
                hwm <= '0;
            end else if (cnt_next_s > hwm) begin
                hwm <= cnt_next_s;
            end
        end
    end

    // One-cycle error pulses for refused requests; a flush suppresses them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            wr_overflow  <= !clr && wr_ena && wr_full;
            rd_underflow <= !clr && rd_ena && rd_empty;
        end
    end

`ifdef FIFO_SYNC_FWFT_EN
    assign rd_dat = mem_r[rd_ptr_r];
`else
    // Registered read: rd_dat holds the last popped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat <= '0;
        end else if (pop_acc_s) begin
            rd_dat <= mem_r[rd_ptr_r];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ex.sv
// Randomised scoreboard bench for fifo_sync_ex against a queue-based reference model.
// Builds for both read modes; FIFO_SYNC_FWFT_EN selects the FWFT expectations.
module tb_fifo_sync_ex;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst, clr, wr_ena, rd_ena;
    logic [7:0] wr_dat, rd_dat;
    logic       wr_full, almost_full, wr_overflow;
    logic       rd_empty, almost_empty, rd_underflow;
    logic [4:0] dat_cnt, hwm;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int         hwm_m    = 0;
    logic       ovf_m    = 1'b0;
    logic       unf_m    = 1'b0;
    logic [7:0] last_rd_m = 8'h00;

    fifo_sync_ex dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_full(wr_full),
        .almost_full(almost_full), .wr_overflow(wr_overflow),
        .rd_ena(rd_ena), .rd_dat(rd_dat), .rd_empty(rd_empty),
        .almost_empty(almost_empty), .rd_underflow(rd_underflow),
        .dat_cnt(dat_cnt), .hwm(hwm)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_dat_cnt", 32'(dat_cnt), 32'd0);
        check("rst_hwm", 32'(hwm), 32'd0);
        check("rst_rd_empty", 32'(rd_empty), 32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_wr_full", 32'(wr_full), 32'd0);
        check("rst_almost_full", 32'(almost_full), 32'd0);
        check("rst_wr_overflow", 32'(wr_overflow), 32'd0);
        check("rst_rd_underflow", 32'(rd_underflow), 32'd0);
`ifndef FIFO_SYNC_FWFT_EN
        check("rst_rd_dat", 32'(rd_dat), 32'd0);
`endif
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        check("dat_cnt", 32'(dat_cnt), 32'(n));
        check("wr_full", 32'(wr_full), 32'(n == DEPTH));
        check("rd_empty", 32'(rd_empty), 32'(n == 0));
        check("almost_full", 32'(almost_full), 32'(n >= AF));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check("hwm", 32'(hwm), 32'(hwm_m));
        check("wr_overflow", 32'(wr_overflow), 32'(ovf_m));
        check("rd_underflow", 32'(rd_underflow), 32'(unf_m));
`ifdef FIFO_SYNC_FWFT_EN
        if (n > 0) check("rd_dat_head", 32'(rd_dat), 32'(mq[0]));
`else
        check("rd_dat", 32'(rd_dat), 32'(last_rd_m));
`endif
    endtask

    // One clock of stimulus: drive at negedge, update the model, check after the edge.
    task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic cl);
        logic [7:0] v;
        bit full, empty;
        @(negedge clk);
        wr_ena = we; wr_dat = wd; rd_ena = re; clr = cl;
        if (cl) begin
            mq.delete();
            hwm_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
        end else begin
            full  = (mq.size() == DEPTH);
            empty = (mq.size() == 0);
            ovf_m = we && full;
            unf_m = re && empty;
            if (re && !empty) begin
                v = mq.pop_front();
                exp_q.push_back(v);
                last_rd_m = v;
            end
            if (we && !full) mq.push_back(wd);
            if (mq.size() > hwm_m) hwm_m = mq.size();
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        mq.delete(); exp_q.delete();
        hwm_m = 0; ovf_m = 1'b0; unf_m = 1'b0; last_rd_m = 8'h00;
        @(negedge clk);
        rst = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0; clr = 1'b0;
    endtask

    // Monitor: notes an accepted pop before the edge and compares the popped word to the scoreboard.
    initial begin
        logic       pend;
        logic [7:0] d_pre;
        forever begin
            @(negedge clk);
            #1;
            pend  = !rst && rd_ena && !rd_empty && !clr;
            d_pre = rd_dat;
            @(posedge clk);
            #1;
            if (pend && !rst) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop", 32'd1, 32'd0);
                end else begin
`ifdef FIFO_SYNC_FWFT_EN
                    check("sb_pop_data", 32'(d_pre), 32'(exp_q.pop_front()));
`else
                    check("sb_pop_data", 32'(rd_dat), 32'(exp_q.pop_front()));
`endif
                end
            end
        end
    end

    initial begin
        int wp;
        rst = 1'b1; clr = 1'b0; wr_ena = 1'b0; rd_ena = 1'b0; wr_dat = 8'h00;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        // Fill past full, then drain past empty.
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Threshold crossings.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Wrap-around.
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous streaming.
        step(1'b1, 8'd9, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b1, 8'd9, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with a concurrent push.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Async reset mid-burst, then head word after release.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        wr_ena = 1'b1; wr_dat = 8'hEE;
        async_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with alternating bias.
        for (int i = 0; i < 2000; i++) begin
            wp = ((i / 200) % 2 == 1) ? 75 : 25;
            step(($urandom_range(0, 99) < wp), 8'($urandom),
                 ($urandom_range(0, 99) < (100 - wp)), ($urandom_range(0, 149) == 0));
        end

        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
